// File: rtl/onehot_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onehot_seq_pkg
// Brief    : Shared mode encoding and index-width helper for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package onehot_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_WRAP   = 2'd0,
        SEQ_SAT    = 2'd1,
        SEQ_BOUNCE = 2'd2,
        SEQ_RSVD   = 2'd3
    } seq_mode_e;

    // Index width never drops below one bit, even for tiny N.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_sequencer_dec.sv
`default_nettype none
// ============================================================================
// Module   : onehot_sequencer_dec
// Brief    : Combinational binary-to-one-hot decoder with N outputs.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_sequencer_dec
    import onehot_seq_pkg::*;
#(
    parameter  int N = 16,
    localparam int W = idx_w(N)
) (
    input  logic [W-1:0] i_bin,
    output logic [N-1:0] o_one_hot
);

    for (genvar g = 0; g < N; g++) begin : g_bit
        assign o_one_hot[g] = (i_bin == W'(g));
    end

endmodule
`default_nettype wire

// File: rtl/onehot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : onehot_sequencer
// Brief    : Registered one-hot sequencer with load, up/down stepping and
//            wrap / saturate / bounce end behaviour. Optional sticky error
//            on out-of-range loads is enabled by ONEHOT_SEQ_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_sequencer
    import onehot_seq_pkg::*;
#(
    parameter  int N         = 16,
    parameter  int RESET_IDX = 0,
    localparam int W         = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef ONEHOT_SEQ_ERR_EN
    input  logic         err_clr,
    output logic         err,
`endif
    input  logic         en,
    input  logic         dir,
    input  logic [1:0]   mode,
    input  logic         load,
    input  logic [W-1:0] load_idx,
    output logic [W-1:0] index,
    output logic [N-1:0] one_hot,
    output logic         wrap,
    output logic         at_end
);

    localparam logic [W-1:0] c_last   = W'(N - 1);
    localparam logic [W-1:0] c_penult = W'(N - 2);
    localparam logic [W-1:0] c_one    = W'(1);
    localparam logic [W-1:0] c_reset  = W'(RESET_IDX);
    localparam logic [W:0]   c_n_ext  = N[W:0];

    logic [W-1:0] r_index;
    logic         r_flip;
    logic         r_wrap;
    logic [W-1:0] w_index_nxt;
    logic         w_flip_nxt;
    logic         w_wrap_nxt;
    logic         w_edir;
    logic         w_at_end;
    logic         w_load_bad;
    seq_mode_e    w_mode;
`ifdef ONEHOT_SEQ_ERR_EN
    logic         r_err;
    logic         w_err_set;
`endif

    assign w_mode     = seq_mode_e'(mode);
    assign w_edir     = dir ^ r_flip;
    assign w_at_end   = w_edir ? (r_index == '0) : (r_index == c_last);
    // Widened compare keeps the test meaningful when N is a power of two.
    assign w_load_bad = ({1'b0, load_idx} >= c_n_ext);

    always_comb begin
        w_index_nxt = r_index;
        w_flip_nxt  = (w_mode == SEQ_BOUNCE) ? r_flip : 1'b0;
        w_wrap_nxt  = 1'b0;
`ifdef ONEHOT_SEQ_ERR_EN
        w_err_set   = 1'b0;
`endif
        if (load) begin
            if (w_load_bad) begin
`ifdef ONEHOT_SEQ_ERR_EN
                w_err_set   = 1'b1;
`else
                w_index_nxt = c_last;
                w_flip_nxt  = 1'b0;
`endif
            end else begin
                w_index_nxt = load_idx;
                w_flip_nxt  = 1'b0;
            end
        end else if (en) begin
            if (!w_at_end) begin
                w_index_nxt = w_edir ? (r_index - c_one) : (r_index + c_one);
            end else begin
                case (w_mode)
                    SEQ_SAT: begin
                        w_index_nxt = r_index;
                    end
                    SEQ_BOUNCE: begin
                        // Turn around and immediately take one step the other way.
                        w_flip_nxt  = ~r_flip;
                        w_index_nxt = w_edir ? c_one : c_penult;
                        w_wrap_nxt  = 1'b1;
                    end
                    default: begin
                        w_index_nxt = w_edir ? c_last : '0;
                        w_wrap_nxt  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index <= c_reset;
            r_flip  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_index <= w_index_nxt;
            r_flip  <= w_flip_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

`ifdef ONEHOT_SEQ_ERR_EN
    // A fresh error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`endif

    onehot_sequencer_dec #(.N(N)) u_dec (
        .i_bin     (r_index),
        .o_one_hot (one_hot)
    );

    assign index  = r_index;
    assign wrap   = r_wrap;
    assign at_end = w_at_end;

endmodule
`default_nettype wire

// File: tb/tb_onehot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_sequencer
// Brief    : Self-checking bench: three sequencer instances (N=16/5/4) checked
//            against an arithmetic reference model; honours ONEHOT_SEQ_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_sequencer;

    typedef struct { int idx; int flip; int wrp; int err; } mstate_t;
    typedef struct { logic [31:0] idx; logic [31:0] oh; logic [31:0] wrp; logic [31:0] at_end; logic [31:0] err; } obs_t;

`ifdef ONEHOT_SEQ_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_v   [3];
    logic       dir_v  [3];
    logic       load_v [3];
    logic       eclr_v [3];
    logic [1:0] mode_v [3];
    int         lidx_v [3];

    logic [3:0]  idx0;
    logic [15:0] oh0;
    logic [2:0]  idx1;
    logic [4:0]  oh1;
    logic [1:0]  idx2;
    logic [3:0]  oh2;
    logic        wrap0, wrap1, wrap2;
    logic        end0, end1, end2;
    logic        err0, err1, err2;

    mstate_t ms [3];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

`ifndef ONEHOT_SEQ_ERR_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
    assign err2 = 1'b0;
`endif

    onehot_sequencer #(.N(16), .RESET_IDX(3)) u_d16 (
        .clk(clk), .rst_n(rst_n),
`ifdef ONEHOT_SEQ_ERR_EN
        .err_clr(eclr_v[0]), .err(err0),
`endif
        .en(en_v[0]), .dir(dir_v[0]), .mode(mode_v[0]), .load(load_v[0]),
        .load_idx(lidx_v[0][3:0]), .index(idx0), .one_hot(oh0), .wrap(wrap0), .at_end(end0));

    onehot_sequencer #(.N(5), .RESET_IDX(0)) u_d5 (
        .clk(clk), .rst_n(rst_n),
`ifdef ONEHOT_SEQ_ERR_EN
        .err_clr(eclr_v[1]), .err(err1),
`endif
        .en(en_v[1]), .dir(dir_v[1]), .mode(mode_v[1]), .load(load_v[1]),
        .load_idx(lidx_v[1][2:0]), .index(idx1), .one_hot(oh1), .wrap(wrap1), .at_end(end1));

    onehot_sequencer #(.N(4), .RESET_IDX(0)) u_d4 (
        .clk(clk), .rst_n(rst_n),
`ifdef ONEHOT_SEQ_ERR_EN
        .err_clr(eclr_v[2]), .err(err2),
`endif
        .en(en_v[2]), .dir(dir_v[2]), .mode(mode_v[2]), .load(load_v[2]),
        .load_idx(lidx_v[2][1:0]), .index(idx2), .one_hot(oh2), .wrap(wrap2), .at_end(end2));

    function automatic int nk(input int k);
        return (k == 0) ? 16 : (k == 1) ? 5 : 4;
    endfunction

    function automatic int rk(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    function automatic int wk(input int k);
        return (k == 0) ? 4 : (k == 1) ? 3 : 2;
    endfunction

    function automatic mstate_t reset_state(input int k);
        mstate_t s;
        s.idx = rk(k); s.flip = 0; s.wrp = 0; s.err = 0;
        return s;
    endfunction

    // Reference: direction as +1/-1, position leaving 0..n-1 triggers the end rule.
    function automatic mstate_t model_next(input int n, input mstate_t s, input bit en, input bit dir,
                                           input int mode, input bit load, input int lidx, input bit eclr);
        mstate_t r;
        int d;
        int t;
        bit set;
        r = s;
        set = 1'b0;
        d = (((dir ? 1 : 0) ^ s.flip) != 0) ? -1 : 1;
        r.wrp = 0;
        if (mode != 2) r.flip = 0;
        if (load) begin
            if (lidx >= n) begin
                if (ERR_EN) begin
                    set = 1'b1;
                    r.err = 1;
                end else begin
                    r.idx = n - 1;
                    r.flip = 0;
                end
            end else begin
                r.idx = lidx;
                r.flip = 0;
            end
        end else if (en) begin
            t = s.idx + d;
            if (t >= 0 && t < n) r.idx = t;
            else if (mode == 1) r.idx = s.idx;
            else if (mode == 2) begin
                r.flip = 1 - s.flip;
                r.idx = s.idx - d;
                r.wrp = 1;
            end else begin
                r.idx = (t + n) % n;
                r.wrp = 1;
            end
        end
        if (ERR_EN && eclr && !set) r.err = 0;
        return r;
    endfunction

    function automatic int model_end(input int n, input mstate_t s, input bit dir);
        if (((dir ? 1 : 0) ^ s.flip) != 0) return (s.idx == 0) ? 1 : 0;
        return (s.idx == n - 1) ? 1 : 0;
    endfunction

    function automatic obs_t get_obs(input int k);
        obs_t o;
        case (k)
            0: begin o.idx = 32'(idx0); o.oh = 32'(oh0); o.wrp = 32'(wrap0); o.at_end = 32'(end0); o.err = 32'(err0); end
            1: begin o.idx = 32'(idx1); o.oh = 32'(oh1); o.wrp = 32'(wrap1); o.at_end = 32'(end1); o.err = 32'(err1); end
            default: begin o.idx = 32'(idx2); o.oh = 32'(oh2); o.wrp = 32'(wrap2); o.at_end = 32'(end2); o.err = 32'(err2); end
        endcase
        return o;
    endfunction

    task automatic idle(input int k);
        en_v[k] = 1'b0; load_v[k] = 1'b0; eclr_v[k] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) ms[k] = reset_state(k);
            else ms[k] = model_next(nk(k), ms[k], en_v[k], dir_v[k], int'(mode_v[k]),
                                    load_v[k], lidx_v[k], eclr_v[k]);
        end
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle(k); dir_v[k] = 1'b0; mode_v[k] = 2'd0; lidx_v[k] = 0;
            ms[k] = reset_state(k);
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            o = get_obs(k);
            vectors++;
            if (o.idx !== rk(k) || o.oh !== (1 << rk(k)) || o.wrp !== 0 || o.err !== 0) begin
                miscompares++;
                $display("FAIL reset[%0d]: idx=%0d oh=%0h wrap=%0d err=%0d, expected idx=%0d oh=%0h wrap=0 err=0",
                         k, o.idx, o.oh, o.wrp, o.err, rk(k), 1 << rk(k));
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_up16();
        obs_t o;
        int ei, ew, ee;
        en_v[0] = 1'b1; dir_v[0] = 1'b0; mode_v[0] = 2'd0;
        for (int i = 1; i <= 13; i++) begin
            tick();
            o = get_obs(0);
            ei = (i == 13) ? 0 : 3 + i;
            ew = (i == 13) ? 1 : 0;
            ee = (ei == 15) ? 1 : 0;
            vectors++;
            if (o.idx !== ei || o.oh !== (1 << ei) || o.wrp !== ew || o.at_end !== ee) begin
                miscompares++;
                $display("FAIL wrap_up16 step %0d: idx=%0d oh=%0h wrap=%0d at_end=%0d, expected idx=%0d oh=%0h wrap=%0d at_end=%0d",
                         i, o.idx, o.oh, o.wrp, o.at_end, ei, 1 << ei, ew, ee);
            end
        end
        idle(0);
        tick();
        o = get_obs(0);
        vectors++;
        if (o.idx !== 0 || o.wrp !== 0) begin
            miscompares++;
            $display("FAIL wrap_up16 hold: idx=%0d wrap=%0d, expected idx=0 wrap=0", o.idx, o.wrp);
        end
    endtask

    task automatic test_wrap_down5();
        obs_t o;
        int ei;
        load_v[1] = 1'b1; lidx_v[1] = 0; mode_v[1] = 2'd0; dir_v[1] = 1'b1;
        tick();
        load_v[1] = 1'b0; en_v[1] = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            tick();
            o = get_obs(1);
            ei = ((4 - i) % 5 + 5) % 5;
            vectors++;
            if (o.idx !== ei || o.oh !== (1 << ei) || o.wrp !== ((ei == 4) ? 1 : 0) || o.idx >= 5) begin
                miscompares++;
                $display("FAIL wrap_down5 step %0d: idx=%0d oh=%0h wrap=%0d, expected idx=%0d oh=%0h wrap=%0d",
                         i, o.idx, o.oh, o.wrp, ei, 1 << ei, (ei == 4) ? 1 : 0);
            end
        end
        idle(1);
        tick();
    endtask

    task automatic test_sat5();
        obs_t o;
        load_v[1] = 1'b1; lidx_v[1] = 3; mode_v[1] = 2'd1; dir_v[1] = 1'b0;
        tick();
        load_v[1] = 1'b0; en_v[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            o = get_obs(1);
            vectors++;
            if (o.idx !== 4 || o.oh !== 32'h10 || o.wrp !== 0 || o.at_end !== 1) begin
                miscompares++;
                $display("FAIL sat5 step %0d: idx=%0d oh=%0h wrap=%0d at_end=%0d, expected idx=4 oh=10 wrap=0 at_end=1",
                         i, o.idx, o.oh, o.wrp, o.at_end);
            end
        end
        idle(1);
        tick();
    endtask

    task automatic test_bounce4();
        obs_t o;
        int exp_seq [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
        int ew;
        load_v[2] = 1'b1; lidx_v[2] = 0; mode_v[2] = 2'd2; dir_v[2] = 1'b0;
        tick();
        load_v[2] = 1'b0; en_v[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            o = get_obs(2);
            ew = (i == 3 || i == 6) ? 1 : 0;
            vectors++;
            if (o.idx !== exp_seq[i] || o.oh !== (1 << exp_seq[i]) || o.wrp !== ew) begin
                miscompares++;
                $display("FAIL bounce4 step %0d: idx=%0d oh=%0h wrap=%0d, expected idx=%0d oh=%0h wrap=%0d",
                         i, o.idx, o.oh, o.wrp, exp_seq[i], 1 << exp_seq[i], ew);
            end
        end
        idle(2);
        tick();
    endtask

    task automatic test_load_priority();
        obs_t o;
        en_v[0] = 1'b1; load_v[0] = 1'b1; lidx_v[0] = 9; mode_v[0] = 2'd0; dir_v[0] = 1'b0;
        tick();
        o = get_obs(0);
        vectors++;
        if (o.idx !== 9 || o.oh !== 32'h200 || o.wrp !== 0) begin
            miscompares++;
            $display("FAIL load_priority: idx=%0d oh=%0h wrap=%0d, expected idx=9 oh=200 wrap=0", o.idx, o.oh, o.wrp);
        end
        load_v[0] = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) ms[k] = reset_state(k);
        #1;
        o = get_obs(0);
        vectors++;
        if (o.idx !== 3 || o.oh !== 32'h8 || o.wrp !== 0) begin
            miscompares++;
            $display("FAIL async_reset: idx=%0d oh=%0h wrap=%0d, expected idx=3 oh=8 wrap=0", o.idx, o.oh, o.wrp);
        end
        idle(0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_bad_load();
        obs_t o;
        int ei, ee;
        load_v[1] = 1'b1; lidx_v[1] = 2; mode_v[1] = 2'd0;
        tick();
        lidx_v[1] = 7;
        tick();
        o = get_obs(1);
`ifdef ONEHOT_SEQ_ERR_EN
        ei = 2; ee = 1;
`else
        ei = 4; ee = 0;
`endif
        vectors++;
        if (o.idx !== ei || o.oh !== (1 << ei) || o.err !== ee) begin
            miscompares++;
            $display("FAIL bad_load: idx=%0d oh=%0h err=%0d, expected idx=%0d oh=%0h err=%0d",
                     o.idx, o.oh, o.err, ei, 1 << ei, ee);
        end
`ifdef ONEHOT_SEQ_ERR_EN
        eclr_v[1] = 1'b1;
        tick();
        o = get_obs(1);
        vectors++;
        if (o.err !== 1 || o.idx !== 2) begin
            miscompares++;
            $display("FAIL err_set_wins: err=%0d idx=%0d, expected err=1 idx=2", o.err, o.idx);
        end
        load_v[1] = 1'b0;
        tick();
        o = get_obs(1);
        vectors++;
        if (o.err !== 0) begin
            miscompares++;
            $display("FAIL err_clear: err=%0d, expected 0", o.err);
        end
`endif
        idle(1);
        tick();
    endtask

    task automatic test_random();
        obs_t o;
        int ee;
        for (int k = 0; k < 3; k++) mode_v[k] = 2'($urandom_range(0, 3));
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 3; k++) begin
                en_v[k]   = ($urandom % 4) != 0;
                if ($urandom % 8 == 0) dir_v[k] = ~dir_v[k];
                if ($urandom % 16 == 0) mode_v[k] = 2'($urandom_range(0, 3));
                load_v[k] = ($urandom % 12) == 0;
                lidx_v[k] = int'($urandom % (1 << wk(k)));
                eclr_v[k] = ($urandom % 8) == 0;
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                o = get_obs(k);
                ee = model_end(nk(k), ms[k], dir_v[k]);
                vectors++;
                if (o.idx !== ms[k].idx || o.oh !== (1 << ms[k].idx) || o.wrp !== ms[k].wrp ||
                    o.at_end !== ee || o.err !== ms[k].err) begin
                    miscompares++;
                    $display("FAIL random c%0d n%0d: idx=%0d oh=%0h wrap=%0d at_end=%0d err=%0d, expected idx=%0d oh=%0h wrap=%0d at_end=%0d err=%0d",
                             c, nk(k), o.idx, o.oh, o.wrp, o.at_end, o.err,
                             ms[k].idx, 1 << ms[k].idx, ms[k].wrp, ee, ms[k].err);
                end
            end
        end
        for (int k = 0; k < 3; k++) idle(k);
    endtask

    initial begin
        test_reset();
        test_wrap_up16();
        test_wrap_down5();
        test_sat5();
        test_bounce4();
        test_load_priority();
        test_bad_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_sequencer.md
Name: onehot_sequencer

Overview:
Parametrised, registered one-hot sequencer: a binary index register steps through 0..N-1 and drives a one-hot select bus continuously.
- Supports load, up/down stepping, and wrap, saturate or bounce end behaviour.
- Supports non-power-of-two N.
- Sits beside the combinational binary-to-one-hot decoder. Used as a channel/row select generator for scanned or time-multiplexed datapaths.

Parameters:
- N, 16, number of one-hot outputs (channels); legal N >= 2.
- RESET_IDX, 0, index held after reset; legal 0..N-1.
- W, $clog2(N), index width; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  step request, one step per cycle while high.
- dir  in  1  0 = count up, 1 = count down.
- mode  in  2  end behaviour: 0 WRAP, 1 SAT, 2 BOUNCE, 3 reserved (treated as WRAP).
- load  in  1  synchronous load of load_idx; priority over en.
- load_idx  in  W  index to load.
- index  out  W  current binary index (registered).
- one_hot  out  N  one_hot[index] = 1, all other bits 0.
- wrap  out  1  one-cycle pulse in the cycle after an end event.
- at_end  out  1  index is at the terminal value for the current effective direction (combinational from registers).

Behaviour:
- Reset (async assert, sync release): index = RESET_IDX, one_hot = 1 << RESET_IDX, wrap = 0, flip = 0, err = 0.
- Decoding: one_hot is decoded from the index register.
  - Exactly one bit is high in every cycle, including during reset.
  - No cycle ever shows zero or multiple bits high.
- Effective direction: edir = dir XOR flip.
  - flip is an internal register, used only in BOUNCE.
  - flip is cleared on load and whenever mode != BOUNCE.
- Terminal value: N-1 when edir = 0, 0 when edir = 1. Never 2^W - 1 unless N = 2^W.
- Priority per cycle: load > en > hold.
- Load:
  - index <= load_idx next cycle; flip <= 0; wrap <= 0.
  - If load_idx >= N: without the macro, index <= N-1 (clamp).
- Step (en=1, load=0), one cycle latency:
  - Not at terminal: index += 1 (edir=0) or -= 1 (edir=1); wrap <= 0.
  - At terminal, WRAP: index <= 0 (up) or N-1 (down); wrap <= 1.
  - At terminal, SAT: index holds; wrap <= 0. Repeated en is harmless.
  - At terminal, BOUNCE: flip toggles; index steps one position in the new direction (N-1 -> N-2 / 0 -> 1); wrap <= 1.
- Hold (en=0, load=0): index, flip unchanged; wrap <= 0.
- Direction change: dir may change any cycle; it takes effect on the next step.
- Mode change: takes effect on the next step. Leaving BOUNCE clears flip in the same edge.
- Reset mid-sequence: all state returns to reset values immediately; no wrap pulse is generated.

Optional Feature:
- Macro: ONEHOT_SEQ_ERR_EN.
- Defined:
  - Adds ports err (out, 1) and err_clr (in, 1).
  - A load with load_idx >= N is ignored: index and flip are unchanged.
  - That load sets err (sticky); err clears on err_clr or reset.
  - If set and clear occur in the same cycle, set wins.
- Undefined: no err/err_clr ports; out-of-range loads clamp to N-1.

Decomposition:
- Shared package onehot_seq_pkg:
  - typedef enum logic [1:0] seq_mode_e {SEQ_WRAP, SEQ_SAT, SEQ_BOUNCE, SEQ_RSVD}.
  - Width helper function idx_w(N) returning max(1, $clog2(N)).
- Sub-module: the existing combinational decoder (binary -> one_hot, parameter N), instantiated on the index register.
- Next-index logic, flip register and wrap register stay in the top.

Test Plan:
- Reset, N=16, RESET_IDX=3: after rst_n low -> one_hot=16'h0008, index=3, wrap=0. Then en=1, dir=0, WRAP for 13 cycles -> index 15 then 0, wrap high exactly one cycle, one_hot=16'h0001.
- N=5, WRAP, dir=1 from index 0: one step -> index=4, one_hot=5'b10000, wrap pulse. At no point does index reach 5..7.
- N=5, SAT, dir=0 from 3: 4 steps -> index 4,4,4,4; wrap stays 0; at_end=1.
- N=4, BOUNCE, dir=0, en held 8 cycles from 0 -> index sequence 1,2,3,2,1,0,1,2; wrap pulses after 3->2 and 0->1.
- Load and en asserted together, load_idx=9, N=16 -> index=9 next cycle (load wins). Reset asserted mid-count -> index returns to RESET_IDX asynchronously.
- N=5, load_idx=7:
  - Without the macro -> index=4.
  - With ONEHOT_SEQ_ERR_EN -> index unchanged and err=1. err_clr and a second bad load in the same cycle -> err stays 1.
